// File: rtl/tlb_pkg.sv
// Shared types and width helpers for the set-associative TLB and its PLRU tree.
package tlb_pkg;

    typedef enum logic {
        FL_IDLE  = 1'b0,
        FL_SWEEP = 1'b1
    } flush_state_e;

    typedef enum logic [1:0] {
        REQ_NONE   = 2'd0,
        REQ_LOOKUP = 2'd1,
        REQ_INSERT = 2'd2,
        REQ_FLUSH  = 2'd3
    } req_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int unsigned tag_width(input int unsigned va_w, input int unsigned page_w,
                                              input int unsigned sets);
        return va_w - page_w - clog2(sets);
    endfunction

    function automatic int unsigned ppn_width(input int unsigned pa_w, input int unsigned page_w);
        return pa_w - page_w;
    endfunction

    function automatic int unsigned way_width(input int unsigned ways);
        return (ways > 1) ? clog2(ways) : 1;
    endfunction

    // One bit is kept even for a single way so vectors never collapse to zero width.
    function automatic int unsigned plru_width(input int unsigned ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

    // Flush beats insert beats lookup; the losers are dropped.
    function automatic req_e req_decode(input logic fl, input logic ins, input logic lk);
        if (fl)  return REQ_FLUSH;
        if (ins) return REQ_INSERT;
        if (lk)  return REQ_LOOKUP;
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree-PLRU for one set: victim walk and touch update, heap-ordered node bits
// (node n has children 2n+1 / 2n+2, bit 0 points at the lower half).
module plru_tree
    import tlb_pkg::*;
#(
    parameter int unsigned WAYS = 4
) (
    input  logic [plru_width(WAYS)-1:0] plru_i,
    input  logic [way_width(WAYS)-1:0]  touch_i,
    output logic [way_width(WAYS)-1:0]  victim_c,
    output logic [plru_width(WAYS)-1:0] plru_upd_c
);
    localparam int unsigned LVL    = clog2(WAYS);
    localparam int unsigned PLRU_W = plru_width(WAYS);
    localparam int unsigned WAY_W  = way_width(WAYS);
    localparam int unsigned PIDX_W = (PLRU_W > 1) ? clog2(PLRU_W) : 1;

    always_comb begin
        int unsigned node;
        logic        b;
        victim_c   = '0;
        plru_upd_c = plru_i;
        b          = 1'b0;
        node       = 0;
        for (int unsigned l = 0; l < LVL; l++) begin
            b = plru_i[PIDX_W'(node)];
            victim_c[WAY_W-1-l] = b;
            node = 2 * node + 1 + 32'(b);
        end
        // Point every node on the accessed path at the opposite half.
        node = 0;
        for (int unsigned l = 0; l < LVL; l++) begin
            b = touch_i[WAY_W-1-l];
            plru_upd_c[PIDX_W'(node)] = ~b;
            node = 2 * node + 1 + 32'(b);
        end
    end

endmodule

// File: rtl/tlb_assoc.sv
// Set-associative PCID-tagged TLB with tree-PLRU replacement and a set-by-set flush sweep.
// Optional hit/miss/insert counters are built when TLB_STATS_EN is defined.
module tlb_assoc
    import tlb_pkg::*;
#(
    parameter int unsigned VA_W   = 64,
    parameter int unsigned PA_W   = 64,
    parameter int unsigned PCID_W = 12,
    parameter int unsigned PAGE_W = 12,
    parameter int unsigned SETS   = 8,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned CNT_W  = 64
) (
    input  logic              clk,
    input  logic              shutdown,
    input  logic              lookup,
    input  logic              insert,
    input  logic              flush,
    input  logic [VA_W-1:0]   va,
    input  logic [PA_W-1:0]   pa,
    input  logic [PCID_W-1:0] pcid,
    output logic              busy,
    output logic              hit,
    output logic              miss,
    output logic [PA_W-1:0]   ta,
    output logic [CNT_W-1:0]  stat_hit,
    output logic [CNT_W-1:0]  stat_miss,
    output logic [CNT_W-1:0]  stat_insert
);
    localparam int unsigned IDX_W  = clog2(SETS);
    localparam int unsigned TAG_W  = tag_width(VA_W, PAGE_W, SETS);
    localparam int unsigned PPN_W  = ppn_width(PA_W, PAGE_W);
    localparam int unsigned WAY_W  = way_width(WAYS);
    localparam int unsigned PLRU_W = plru_width(WAYS);

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
    logic [PCID_W-1:0] epcid_q [SETS][WAYS];
    logic [PCID_W-1:0] epcid_d [SETS][WAYS];
    logic [PPN_W-1:0]  ppn_q   [SETS][WAYS];
    logic [PPN_W-1:0]  ppn_d   [SETS][WAYS];
    logic [PLRU_W-1:0] plru_q  [SETS];
    logic [PLRU_W-1:0] plru_d  [SETS];

    flush_state_e      state_q, state_d;
    logic [IDX_W-1:0]  sweep_q, sweep_d;
    logic [PCID_W-1:0] fl_pcid_q, fl_pcid_d;
    logic              busy_q, busy_d;
    logic              hit_q, hit_d;
    logic              miss_q, miss_d;
    logic [PA_W-1:0]   ta_q, ta_d;

    req_e              req_c;
    logic [IDX_W-1:0]  idx_c;
    logic [TAG_W-1:0]  tag_c;
    logic [PPN_W-1:0]  ppn_in_c;
    logic              hit_any_c, inv_any_c;
    logic [WAY_W-1:0]  hit_way_c, inv_way_c, ins_way_c, touch_way_c;
    logic [WAY_W-1:0]  victim_c;
    logic [PLRU_W-1:0] plru_upd_c;
    logic              ins_acc_c;

    logic unused_ok;
    assign unused_ok = ^pa[PAGE_W-1:0];

    // Request decode and way matching on the request set.
    always_comb begin
        req_c     = req_decode(flush, insert, lookup);
        idx_c     = va[PAGE_W +: IDX_W];
        tag_c     = va[VA_W-1 -: TAG_W];
        ppn_in_c  = pa[PA_W-1 -: PPN_W];
        hit_any_c = 1'b0;
        hit_way_c = '0;
        inv_any_c = 1'b0;
        inv_way_c = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[idx_c][w] && tag_q[idx_c][w] == tag_c && epcid_q[idx_c][w] == pcid) begin
                hit_any_c = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!valid_q[idx_c][w]) begin
                inv_any_c = 1'b1;
                inv_way_c = WAY_W'(w);
            end
        end
        ins_way_c   = hit_any_c ? hit_way_c : (inv_any_c ? inv_way_c : victim_c);
        touch_way_c = (req_c == REQ_INSERT) ? ins_way_c : hit_way_c;
        ins_acc_c   = (state_q == FL_IDLE) && (req_c == REQ_INSERT);
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_i     (plru_q[idx_c]),
        .touch_i    (touch_way_c),
        .victim_c   (victim_c),
        .plru_upd_c (plru_upd_c)
    );

    // Flush FSM plus array/response next-state.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        fl_pcid_d = fl_pcid_q;
        busy_d    = busy_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        ta_d      = ta_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        epcid_d   = epcid_q;
        ppn_d     = ppn_q;
        plru_d    = plru_q;
        case (state_q)
            FL_IDLE: begin
                case (req_c)
                    REQ_FLUSH: begin
                        state_d   = FL_SWEEP;
                        busy_d    = 1'b1;
                        sweep_d   = '0;
                        fl_pcid_d = pcid;
                    end
                    REQ_INSERT: begin
                        valid_d[idx_c][ins_way_c] = 1'b1;
                        tag_d[idx_c][ins_way_c]   = tag_c;
                        epcid_d[idx_c][ins_way_c] = pcid;
                        ppn_d[idx_c][ins_way_c]   = ppn_in_c;
                        plru_d[idx_c]             = plru_upd_c;
                    end
                    REQ_LOOKUP: begin
                        if (hit_any_c) begin
                            hit_d         = 1'b1;
                            ta_d          = {ppn_q[idx_c][hit_way_c], va[PAGE_W-1:0]};
                            plru_d[idx_c] = plru_upd_c;
                        end else begin
                            miss_d = 1'b1;
                            ta_d   = '0;
                        end
                    end
                    default: ;
                endcase
            end
            FL_SWEEP: begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    if (fl_pcid_q == '1 || epcid_q[sweep_q][w] == fl_pcid_q) begin
                        valid_d[sweep_q][w] = 1'b0;
                    end
                end
                if (sweep_q == IDX_W'(SETS - 1)) begin
                    state_d = FL_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            default: begin
                state_d = FL_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (shutdown) begin
            state_q   <= FL_IDLE;
            sweep_q   <= '0;
            fl_pcid_q <= '0;
            busy_q    <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            ta_q      <= '0;
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            fl_pcid_q <= fl_pcid_d;
            busy_q    <= busy_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            ta_q      <= ta_d;
            valid_q   <= valid_d;
            plru_q    <= plru_d;
        end
    end

    // Payload fields are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q   <= tag_d;
        epcid_q <= epcid_d;
        ppn_q   <= ppn_d;
    end

    assign busy = busy_q;
    assign hit  = hit_q;
    assign miss = miss_q;
    assign ta   = ta_q;

`ifdef TLB_STATS_EN
    logic [CNT_W-1:0] stat_hit_q, stat_hit_d;
    logic [CNT_W-1:0] stat_miss_q, stat_miss_d;
    logic [CNT_W-1:0] stat_insert_q, stat_insert_d;

    // Saturating event counters.
    always_comb begin
        stat_hit_d    = stat_hit_q;
        stat_miss_d   = stat_miss_q;
        stat_insert_d = stat_insert_q;
        if (hit_d && stat_hit_q != '1)          stat_hit_d    = stat_hit_q + 1'b1;
        if (miss_d && stat_miss_q != '1)        stat_miss_d   = stat_miss_q + 1'b1;
        if (ins_acc_c && stat_insert_q != '1)   stat_insert_d = stat_insert_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (shutdown) begin
            stat_hit_q    <= '0;
            stat_miss_q   <= '0;
            stat_insert_q <= '0;
        end else begin
            stat_hit_q    <= stat_hit_d;
            stat_miss_q   <= stat_miss_d;
            stat_insert_q <= stat_insert_d;
        end
    end

    assign stat_hit    = stat_hit_q;
    assign stat_miss   = stat_miss_q;
    assign stat_insert = stat_insert_q;
`else
    logic unused_stats_ok;
    assign unused_stats_ok = ins_acc_c;
    assign stat_hit    = '0;
    assign stat_miss   = '0;
    assign stat_insert = '0;
`endif

endmodule

// File: tb/tb_tlb_assoc.sv
// Scoreboard bench for tlb_assoc: directed scenarios then randomized traffic against a behavioural model.
module tb_tlb_assoc;
    localparam int unsigned SETS   = 8;
    localparam int unsigned WAYS   = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CNT_MX = (1 << CNT_W) - 1;
`ifdef TLB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             shutdown, lookup, insert, flush;
    logic [63:0]      va, pa;
    logic [11:0]      pcid;
    logic             busy, hit, miss;
    logic [63:0]      ta;
    logic [CNT_W-1:0] stat_hit, stat_miss, stat_insert;

    always #5 clk = ~clk;

    tlb_assoc #(
        .VA_W(64), .PA_W(64), .PCID_W(12), .PAGE_W(12),
        .SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .shutdown(shutdown), .lookup(lookup), .insert(insert), .flush(flush),
        .va(va), .pa(pa), .pcid(pcid), .busy(busy), .hit(hit), .miss(miss), .ta(ta),
        .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_insert(stat_insert)
    );

    typedef struct {
        logic        hit;
        logic [63:0] ta;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model: entries keyed by full virtual page number.
    bit          m_valid [SETS][WAYS];
    logic [51:0] m_vpn   [SETS][WAYS];
    logic [11:0] m_pcid  [SETS][WAYS];
    logic [51:0] m_ppn   [SETS][WAYS];
    bit          m_plru  [SETS][WAYS];
    int          m_busy;
    int unsigned m_hit, m_miss, m_ins;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int unsigned bump(input int unsigned c);
        if (!STATS_ON) return 0;
        return (c >= CNT_MX) ? CNT_MX : c + 1;
    endfunction

    function automatic int find(input logic [63:0] v, input logic [11:0] pc);
        int s;
        s = int'(v[14:12]);
        for (int w = 0; w < int'(WAYS); w++)
            if (m_valid[s][w] && m_vpn[s][w] == v[63:12] && m_pcid[s][w] == pc) return w;
        return -1;
    endfunction

    // Walk halves of the way range: bit 1 sends the victim search to the upper half.
    function automatic int plru_victim(input int s);
        int node, lo, n;
        node = 0; lo = 0; n = int'(WAYS);
        while (n > 1) begin
            n = n / 2;
            if (m_plru[s][node]) begin lo += n; node = 2 * node + 2; end
            else node = 2 * node + 1;
        end
        return lo;
    endfunction

    task automatic plru_touch(input int s, input int w);
        int node, lo, n;
        node = 0; lo = 0; n = int'(WAYS);
        while (n > 1) begin
            n = n / 2;
            if (w >= lo + n) begin m_plru[s][node] = 1'b0; lo += n; node = 2 * node + 2; end
            else begin m_plru[s][node] = 1'b1; node = 2 * node + 1; end
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < int'(SETS); s++)
            for (int w = 0; w < int'(WAYS); w++) begin
                m_valid[s][w] = 1'b0;
                m_plru[s][w]  = 1'b0;
            end
        m_busy = 0; m_hit = 0; m_miss = 0; m_ins = 0;
    endtask

    task automatic model_lookup(input logic [63:0] v, input logic [11:0] pc);
        int   s, w;
        exp_t e;
        s = int'(v[14:12]);
        w = find(v, pc);
        e.cyc = cyc;
        if (w >= 0) begin
            e.hit = 1'b1;
            e.ta  = {m_ppn[s][w], v[11:0]};
            plru_touch(s, w);
            m_hit = bump(m_hit);
        end else begin
            e.hit = 1'b0;
            e.ta  = '0;
            m_miss = bump(m_miss);
        end
        exp_q.push_back(e);
    endtask

    task automatic model_insert(input logic [63:0] v, input logic [63:0] p, input logic [11:0] pc);
        int s, w;
        s = int'(v[14:12]);
        w = find(v, pc);
        if (w < 0)
            for (int k = 0; k < int'(WAYS); k++)
                if (w < 0 && !m_valid[s][k]) w = k;
        if (w < 0) w = plru_victim(s);
        m_valid[s][w] = 1'b1;
        m_vpn[s][w]   = v[63:12];
        m_pcid[s][w]  = pc;
        m_ppn[s][w]   = p[63:12];
        plru_touch(s, w);
        m_ins = bump(m_ins);
    endtask

    task automatic model_flush(input logic [11:0] pc);
        for (int s = 0; s < int'(SETS); s++)
            for (int w = 0; w < int'(WAYS); w++)
                if (pc == 12'hfff || m_pcid[s][w] == pc) m_valid[s][w] = 1'b0;
    endtask

    // One clock of stimulus; the model decides acceptance from its own busy countdown.
    task automatic step(input logic sd, input logic lk, input logic ins, input logic fl,
                        input logic [63:0] v, input logic [63:0] p, input logic [11:0] pc);
        @(negedge clk);
        chk("busy", busy, (m_busy > 0));
        shutdown = sd; lookup = lk; insert = ins; flush = fl;
        va = v; pa = p; pcid = pc;
        if (sd) model_reset();
        else if (m_busy > 0) m_busy--;
        else if (fl) begin model_flush(pc); m_busy = int'(SETS); end
        else if (ins) model_insert(v, p, pc);
        else if (lk) model_lookup(v, pc);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_lk(input logic [63:0] v, input logic [11:0] pc);
        step(1'b0, 1'b1, 1'b0, 1'b0, v, '0, pc);
    endtask

    task automatic do_ins(input logic [63:0] v, input logic [63:0] p, input logic [11:0] pc);
        step(1'b0, 1'b0, 1'b1, 1'b0, v, p, pc);
    endtask

    task automatic check_stats();
        chk("stat_hit", 64'(stat_hit), 64'(m_hit));
        chk("stat_miss", 64'(stat_miss), 64'(m_miss));
        chk("stat_insert", 64'(stat_insert), 64'(m_ins));
    endtask

    // Monitor: every hit/miss pulse must match the oldest outstanding lookup.
    exp_t mon_e;
    always @(negedge clk) begin
        if (hit === 1'b1 || miss === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: hit=%b miss=%b, expected no pulse (cycle %0d)", hit, miss, cyc);
            end else begin
                n_pass++;
                mon_e = exp_q.pop_front();
                chk("hit", 64'(hit), 64'(mon_e.hit));
                chk("miss", 64'(miss), 64'(!mon_e.hit));
                chk("ta", ta, mon_e.ta);
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            n_checks++;
            $display("FAIL missing_pulse: hit=%b miss=%b, expected a lookup response (cycle %0d)", hit, miss, cyc);
            void'(exp_q.pop_front());
        end
    end

    function automatic logic [63:0] set0_va(input int t);
        return 64'(t) << 15;
    endfunction

    initial begin
        logic [63:0] v, p, tagv;
        logic [11:0] pc;
        int          sel;

        shutdown = 1'b1; lookup = 1'b0; insert = 1'b0; flush = 1'b0;
        va = '0; pa = '0; pcid = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_hit", 64'(hit), 64'(0));
        chk("reset_miss", 64'(miss), 64'(0));
        chk("reset_ta", ta, 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        check_stats();

        // Basic miss, fill, hit, pcid mismatch.
        do_lk(64'hffff_ffff_ffff_fff1, 12'd0);
        do_ins(64'hffff_ffff_ffff_fff1, 64'h1234_5000, 12'd0);
        do_lk(64'hffff_ffff_ffff_fff1, 12'd0);
        do_lk(64'hffff_ffff_ffff_fff1, 12'd1);
        idle();
        chk("dir_ta_12345ff1", ta, 64'h1234_5ff1 & {64{exp_q.size() == 0}});

        // PLRU: A..D fill set 0, touch A, E evicts C.
        for (int t = 1; t <= 4; t++) do_ins(set0_va(t), 64'(t) << 20, 12'd0);
        do_lk(set0_va(1), 12'd0);
        do_ins(set0_va(5), 64'h5 << 20, 12'd0);
        do_lk(set0_va(3), 12'd0);
        do_lk(set0_va(1), 12'd0);
        do_lk(set0_va(2), 12'd0);
        do_lk(set0_va(4), 12'd0);
        do_lk(set0_va(5), 12'd0);

        // In-place update of A.
        do_ins(set0_va(1), 64'h7777_7000, 12'd0);
        do_lk(set0_va(1) | 64'habc, 12'd0);
        do_lk(set0_va(2), 12'd0);
        do_lk(set0_va(4), 12'd0);
        do_lk(set0_va(5), 12'd0);
        idle();
        check_stats();

        // Flush pcid 1 while pcid 0 entries survive; lookups during busy are dropped.
        for (int s = 1; s < 4; s++) begin
            do_ins((64'd9 << 15) | (64'(s) << 12), 64'(s) << 24, 12'd0);
            do_ins((64'd9 << 15) | (64'(s) << 12), 64'(s) << 28, 12'd1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 12'd1);
        for (int i = 0; i < int'(SETS); i++) do_lk((64'd9 << 15) | (64'd1 << 12), 12'd0);
        for (int s = 1; s < 4; s++) begin
            do_lk((64'd9 << 15) | (64'(s) << 12), 12'd1);
            do_lk((64'd9 << 15) | (64'(s) << 12), 12'd0);
        end

        // Shutdown part-way through a sweep.
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 12'd0);
        repeat (3) idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle();
        for (int s = 1; s < 4; s++) do_lk((64'd9 << 15) | (64'(s) << 12), 12'd0);
        do_lk(set0_va(2), 12'd0);

        // Twenty misses drive the miss counter into saturation.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 20; i++) do_lk(64'(i) << 12, 12'd2);
        idle();
        check_stats();
        chk("stat_miss_sat", 64'(stat_miss), STATS_ON ? 64'(CNT_MX) : 64'(0));

        // Randomized traffic, including simultaneous requests.
        for (int i = 0; i < 1500; i++) begin
            sel  = int'($urandom_range(0, 5));
            tagv = (sel == 5) ? 64'h1_ffff_ffff_ffff : 64'(sel);
            v    = (tagv << 15) | (64'($urandom_range(0, 7)) << 12) | 64'($urandom_range(0, 4095));
            p    = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: pc = 12'd0;
                1: pc = 12'd1;
                2: pc = 12'd2;
                default: pc = 12'hfff;
            endcase
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0), v, p, pc);
            if (i % 250 == 249) check_stats();
        end

        repeat (SETS + 2) idle();
        check_stats();
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tlb_assoc.md
# tlb_assoc

Parametrised set-associative TLB with PCID tagging, tree-PLRU replacement, in-place update and a multi-cycle PCID flush engine. It is the next-generation translation array inside the MMU: it serves lookups from the shared va/pcid request lines, accepts fills from the page walker, and optionally carries PMU-style hit/miss/insert counters.

## Interface
- VA_W, 64, virtual address width
- PA_W, 64, physical address width
- PCID_W, 12, process-context ID width
- PAGE_W, 12, page-offset bits
- SETS, 8, number of sets (power of two, ≥2)
- WAYS, 4, ways per set (power of two, ≥1)
- CNT_W, 64, statistics counter width
- clk  in  1  clock; all state changes on rising edge
- shutdown  in  1  reset, synchronous, active-high
- lookup  in  1  translate va/pcid this cycle
- insert  in  1  write va→pa for pcid this cycle
- flush  in  1  invalidate all entries of pcid (all-ones pcid = every entry)
- va  in  VA_W  request virtual address
- pa  in  PA_W  fill physical address (only the page-number bits are stored)
- pcid  in  PCID_W  request PCID
- busy  out  1  flush sweep in progress; requests ignored
- hit  out  1  one-cycle pulse, lookup matched
- miss  out  1  one-cycle pulse, lookup did not match
- ta  out  PA_W  translated address
- stat_hit, stat_miss, stat_insert  out  CNT_W  event counters

## Operation
- Index = va[PAGE_W +: log2(SETS)]; tag = va bits above the index; an entry holds valid, tag, pcid, ppn.
- Match: valid && tag equal && pcid equal. At most one way matches (guaranteed by in-place update).
- Simultaneous requests: flush > insert > lookup; lower-priority requests that cycle are dropped (no hit/miss).
- Lookup: hit → ta = {ppn, va[PAGE_W-1:0]}, PLRU touched; miss → ta = 0.
- Insert: existing match → ppn overwritten in the same way; else lowest-index invalid way; else PLRU victim. The written way is touched in PLRU.
- PLRU: WAYS-1 bits per set, each node bit points toward the less-recently-used half (0 = lower half); touch sets the path to point away from the accessed way. WAYS=1: no PLRU bits, victim is way 0.
- Flush FSM: IDLE → SWEEP on accepted flush (pcid latched); SWEEP visits set 0..SETS-1, one per cycle, clearing valid on matching ways (all ways if latched pcid is all-ones); after set SETS-1 → IDLE. PLRU bits untouched.
- While busy: lookup/insert/flush inputs ignored, hit/miss stay 0.

## Timing
- Reset (shutdown high at an edge): all valid = 0, PLRU = 0, FSM = IDLE, hit = miss = busy = 0, ta = 0, counters = 0. Reset mid-sweep aborts it.
- Lookup sampled at edge N → hit/miss/ta registered, valid after edge N+1; ta holds until the next accepted lookup.
- Insert sampled at edge N → visible to a lookup sampled at edge N+1.
- Flush sampled at edge N → busy high after N+1 for exactly SETS cycles; first request accepted at the edge where busy is sampled low.

## Configuration
- TLB_STATS_EN defined: stat_hit/stat_miss count hit/miss pulses, stat_insert counts accepted inserts; each saturates at all-ones; cleared by shutdown.
- Undefined: no counter flops; stat_* outputs driven constant 0.

## Structure
- Package tlb_pkg: flush FSM state enum, request-priority encoding, entry field widths derived from parameters, clog2 helper.
- One sub-module: plru_tree (per-set victim select and touch update, parametrised by WAYS).

## Test plan
- Reset, lookup va=64'hfffffffffffffff1 pcid=0 → next cycle miss=1, hit=0, ta=0.
- Insert va=64'hfffffffffffffff1 pa=64'h12345000 pcid=0, lookup same → hit=1, ta=64'h12345ff1; same va pcid=1 → miss=1.
- SETS=8 WAYS=4: insert tags A,B,C,D into set 0, lookup A, insert E → C misses; A,B,D,E hit.
- Re-insert A with pa=64'h77777000 → lookup A gives ta=64'h77777xxx page-offset of va, B,D,E still hit, stat_insert +1.
- Entries for pcid 0 and 1, flush pcid=1 → busy 8 cycles, lookup during busy yields no pulse; afterwards pcid 1 misses, pcid 0 hits; shutdown at sweep cycle 3 → busy=0 next cycle, all miss.
- TLB_STATS_EN, CNT_W=4: 20 misses → stat_miss=15; without macro all stat_* = 0.
